dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 59 +++++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Two-requester data-memory bus: requester ports, grant/response
// and the single memory command/response port.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              m0_req;
  logic              m0_we;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [BE_W-1:0]   m0_be;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [BE_W-1:0]   m1_be;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock,
    input  m0_addr, m0_wdata, m0_be,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock,
    input  m1_addr, m1_wdata, m1_be,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock,
    output m0_addr, m0_wdata, m0_be,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock,
    output m1_addr, m1_wdata, m1_be,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: combinational round-robin grant,
// locked bursts up to MAX_BURST, one-cycle read response routing.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_BURST);
  localparam bit CAN_LOCK = (MAX_BURST > 1);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_e;

  own_e             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;
  logic             pid_q, pid_d;

  logic              gnt0, gnt1;
  logic              held0, held1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    held0   = (state_q == OWN0) && bus.m0_lock;
    held1   = (state_q == OWN1) && bus.m1_lock;

    // last_q=1 means m1 won most recently, so m0 wins the tie
    unique case (1'b1)
      held0: gnt0 = bus.m0_req;
      held1: gnt1 = bus.m1_req;
      default: begin
        gnt0 = bus.m0_req & (~bus.m1_req | last_q);
        gnt1 = bus.m1_req & ~gnt0;
      end
    endcase

    gnt0 = gnt0 & rst_n;
    gnt1 = gnt1 & rst_n;

    if (held0 || held1) begin
      if (gnt0 || gnt1) begin
        if (cnt_q + 1'b1 == CNT_MAX) begin
          state_d = FREE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
    end else begin
      state_d = FREE;
      cnt_d   = '0;
      if (state_q == FREE && CAN_LOCK) begin
        if (gnt0 && bus.m0_lock) begin
          state_d = OWN0;
          cnt_d   = CNT_W'(1);
        end else if (gnt1 && bus.m1_lock) begin
          state_d = OWN1;
          cnt_d   = CNT_W'(1);
        end
      end
    end

    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;

    pend_d = (gnt0 & ~bus.m0_we) |
             (gnt1 & ~bus.m1_we);
    pid_d  = gnt1;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (gnt0) begin
      mem_we    = bus.m0_we;
      mem_addr  = bus.m0_addr;
      mem_wdata = bus.m0_wdata;
      mem_be    = bus.m0_be;
    end else if (gnt1) begin
      mem_we    = bus.m1_we;
      mem_addr  = bus.m1_addr;
      mem_wdata = bus.m1_wdata;
      mem_be    = bus.m1_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FREE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      pend_q  <= 1'b0;
      pid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      pid_q   <= pid_d;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.mem_en    = gnt0 | gnt1;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_be    = mem_be;

  assign bus.m0_rvalid = pend_q & ~pid_q;
  assign bus.m1_rvalid = pend_q &  pid_q;
  assign bus.m0_rdata  =
    bus.m0_rvalid ? bus.mem_rdata : '0;
  assign bus.m1_rdata  =
    bus.m1_rvalid ? bus.mem_rdata : '0;
endmodule
